inst_prefetch: RTL and testbench

INST_PREFETCH -- requirements
Module: inst_prefetch

---
 rtl/proc_pkg.sv | 26 ++
 rtl/pf_fifo.sv | 54 +++++
 rtl/inst_prefetch.sv | 125 ++++++++++++
 tb/tb_inst_prefetch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath widths, the NOP encoding and the
// prefetch FSM state / queue entry types.
package proc_pkg;

  localparam int PC_W   = 16;
  localparam int INST_W = 16;

  localparam logic [INST_W-1:0] NOP_INST = 16'h1000;

  typedef enum logic [1:0] {
    PF_IDLE   = 2'd0,
    PF_REQ    = 2'd1,
    PF_DRAIN  = 2'd2,
    PF_HALTED = 2'd3
  } pf_state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } pf_entry_t;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/pf_fifo.sv
// Prefetch queue: power-of-two circular buffer with occupancy count and a
// synchronous flush that empties it on the next edge.
module pf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  // A full queue can still take a push when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: one outstanding memory read at a time feeding a
// small queue, with redirect flush/drain and a sticky halt.
//   state     | meaning
//   PF_IDLE   | no request outstanding
//   PF_REQ    | request outstanding, returned word will be queued
//   PF_DRAIN  | request outstanding, returned word will be discarded
//   PF_HALTED | fetching stopped until reset
module inst_prefetch
  import proc_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt,
  input  logic              stall,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic [PC_W-1:0]   inst_pcplus1
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = PC_W + INST_W;

  pf_state_t        state;
  pf_state_t        state_nxt;
  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  req_addr;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic [ENT_W-1:0] head_bits;
  pf_entry_t        head;
  pf_entry_t        push_entry;
  logic             outstanding;
  logic             credit_ok;
  logic             issue;
  logic             push;
  logic             pop;
  logic             flush;

  assign outstanding = (state == PF_REQ) || (state == PF_DRAIN);
  // Queued entries plus the in-flight word must leave room for one more.
  assign credit_ok   = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, outstanding})
                       < (CNT_W+1)'(DEPTH);
  assign issue       = (state == PF_IDLE) && !halt && !redirect && credit_ok;
  assign push        = (state == PF_REQ) && mem_ack && !redirect && !halt;
  assign flush       = redirect || halt || (state == PF_HALTED);
  assign pop         = inst_valid && !stall;
  assign push_entry  = '{pc: req_addr, inst: mem_data};
  assign head        = head_bits;

  pf_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_bits),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= PF_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (halt) begin
      state_nxt = PF_HALTED;
    end else begin
      case (state)
        PF_IDLE:   if (issue) state_nxt = PF_REQ;
        PF_REQ: begin
          if (mem_ack)       state_nxt = PF_IDLE;
          else if (redirect) state_nxt = PF_DRAIN;
        end
        PF_DRAIN:  if (mem_ack) state_nxt = PF_IDLE;
        PF_HALTED: state_nxt = PF_HALTED;
        default:   state_nxt = PF_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req      = outstanding;
    mem_addr     = req_addr;
    inst_valid   = !fifo_empty && !redirect && (state != PF_HALTED);
    inst         = NOP_INST;
    inst_pc      = '0;
    inst_pcplus1 = '0;
    if (inst_valid) begin
      inst         = head.inst;
      inst_pc      = head.pc;
      inst_pcplus1 = pc_inc(head.pc);
    end
  end

  // fetch_pc is the next address to request; req_addr holds the in-flight one
  // so it stays stable through DRAIN even while redirects retarget fetch_pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else if (!halt && (state != PF_HALTED)) begin
      if (redirect)  fetch_pc <= redirect_pc;
      else if (push) fetch_pc <= pc_inc(req_addr);
      if (issue)     req_addr <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch with a latency-programmable memory model
// that returns (address ^ 16'hC000) as the instruction word.
module tb_inst_prefetch;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [15:0] inst_pcplus1;

  int n_vec   = 0;
  int n_err   = 0;
  int mem_lat = 1;
  int ack_cnt = 0;

  bit          mem_busy;
  int          mem_age;
  logic [15:0] mem_cap;

  logic [47:0] pop_log [$];

  inst_prefetch dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt         (halt),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_pcplus1 (inst_pcplus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Memory latches a request when first seen and acks mem_lat cycles later,
  // even if the prefetcher has since dropped mem_req.
  initial begin
    mem_ack  = 1'b0;
    mem_data = 16'hDEAD;
    mem_busy = 1'b0;
    mem_age  = 0;
    mem_cap  = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack  = 1'b0;
        mem_data = 16'hDEAD;
      end else if (mem_busy) begin
        mem_age++;
        if (mem_age >= mem_lat + 1) begin
          mem_ack  = 1'b1;
          mem_data = mem_cap ^ 16'hC000;
          mem_busy = 1'b0;
          ack_cnt++;
          if (mem_req) check_val("addr_stable", mem_addr, mem_cap);
        end
      end else if (mem_req) begin
        mem_busy = 1'b1;
        mem_age  = 1;
        mem_cap  = mem_addr;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst && inst_valid && !stall) pop_log.push_back({inst_pc, inst, inst_pcplus1});
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_val("rst_mem_req",    {15'd0, mem_req},    16'd0);
    check_val("rst_mem_addr",   mem_addr,            16'h0000);
    check_val("rst_inst_valid", {15'd0, inst_valid}, 16'd0);
    check_val("rst_inst",       inst,                16'h1000);
    check_val("rst_inst_pc",    inst_pc,             16'h0000);
    check_val("rst_pcplus1",    inst_pcplus1,        16'h0000);
    rst = 1'b0;
    pop_log.delete();
  endtask

  task automatic wait_pops(input string tag, input int n, input int budget);
    while (pop_log.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (pop_log.size() < n) check_val({tag, "_pop_timeout"}, 16'(pop_log.size()), 16'(n));
  endtask

  task automatic check_pop(input string tag, input logic [15:0] exp_pc);
    logic [47:0] e;
    if (pop_log.size() == 0) begin
      check_val({tag, "_missing"}, 16'd0, 16'd1);
      return;
    end
    e = pop_log.pop_front();
    check_val({tag, "_pc"},      e[47:32], exp_pc);
    check_val({tag, "_inst"},    e[31:16], exp_pc ^ 16'hC000);
    check_val({tag, "_pcplus1"}, e[15:0],  exp_pc + 16'd1);
  endtask

  task automatic wait_req_rise(input string tag, output logic [15:0] addr);
    int budget = 60;
    while (mem_req && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    while (!mem_req && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!mem_req) check_val({tag, "_req_timeout"}, 16'd0, 16'd1);
    addr = mem_addr;
  endtask

  task automatic wait_req_addr(input string tag, input logic [15:0] addr, input int budget);
    while (!(mem_req && mem_addr == addr) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!(mem_req && mem_addr == addr)) check_val({tag, "_timeout"}, mem_addr, addr);
  endtask

  task automatic wait_ack(input string tag, input int budget);
    while (!mem_ack && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!mem_ack) check_val({tag, "_ack_timeout"}, 16'd0, 16'd1);
  endtask

  initial begin
    logic [15:0] a;
    int          base;
    bit          seen_req;
    bit          seen_valid;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    halt        = 1'b0;
    stall       = 1'b0;

    // Straight-line fetch, single-cycle-latency memory.
    do_reset();
    @(negedge clk);
    check_val("t1_first_req",  {15'd0, mem_req}, 16'd1);
    check_val("t1_first_addr", mem_addr,         16'h0000);
    @(negedge clk);
    check_val("t1_ack_cycle_valid", {15'd0, inst_valid}, 16'd0);
    @(negedge clk);
    check_val("t1_valid",   {15'd0, inst_valid}, 16'd1);
    check_val("t1_inst",    inst,                16'hC000);
    check_val("t1_pc",      inst_pc,             16'h0000);
    check_val("t1_pcplus1", inst_pcplus1,        16'h0001);
    wait_pops("t1", 4, 60);
    for (int i = 0; i < 4; i++) check_pop("t1_pop", 16'(i));

    // Held stall fills the queue to DEPTH and stops requests.
    stall = 1'b1;
    do_reset();
    base = ack_cnt;
    repeat (40) @(negedge clk);
    check_val("t2_acks",       16'(ack_cnt - base),  16'd4);
    check_val("t2_req_low",    {15'd0, mem_req},     16'd0);
    check_val("t2_head_valid", {15'd0, inst_valid},  16'd1);
    check_val("t2_head_pc",    inst_pc,              16'h0000);
    pop_log.delete();
    stall = 1'b0;
    wait_pops("t2", 5, 60);
    for (int i = 0; i < 5; i++) check_pop("t2_pop", 16'(i));

    // Redirect while a 3-cycle request is in flight: drain it.
    mem_lat = 3;
    do_reset();
    wait_req_addr("t3_req5", 16'h0005, 100);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    check_val("t3_redir_valid", {15'd0, inst_valid}, 16'd0);
    check_val("t3_redir_inst",  inst,                16'h1000);
    pop_log.delete();
    @(negedge clk);
    redirect = 1'b0;
    check_val("t3_drain_req",  {15'd0, mem_req}, 16'd1);
    check_val("t3_drain_addr", mem_addr,         16'h0005);
    wait_req_rise("t3", a);
    check_val("t3_next_addr", a, 16'h0040);
    wait_pops("t3", 1, 40);
    check_pop("t3_pop", 16'h0040);

    // Redirect in the same cycle as an ack: word dropped, no drain.
    wait_ack("t4", 40);
    redirect    = 1'b1;
    redirect_pc = 16'h0080;
    #1;
    check_val("t4_redir_valid", {15'd0, inst_valid}, 16'd0);
    check_val("t4_redir_inst",  inst,                16'h1000);
    pop_log.delete();
    @(negedge clk);
    redirect = 1'b0;
    check_val("t4_idle_req", {15'd0, mem_req}, 16'd0);
    @(negedge clk);
    check_val("t4_next_req",  {15'd0, mem_req}, 16'd1);
    check_val("t4_next_addr", mem_addr,         16'h0080);
    wait_pops("t4", 1, 40);
    check_pop("t4_pop", 16'h0080);

    // Address wrap at the top of the PC space.
    mem_lat = 1;
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    pop_log.delete();
    @(negedge clk);
    redirect = 1'b0;
    wait_pops("t5", 2, 60);
    check_pop("t5_pop_ffff", 16'hFFFF);
    check_pop("t5_pop_wrap", 16'h0000);

    // Halt and redirect together with a request outstanding.
    mem_lat = 3;
    wait_req_rise("t6", a);
    @(negedge clk);
    halt        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    #1;
    check_val("t6_halt_valid", {15'd0, inst_valid}, 16'd0);
    @(negedge clk);
    halt       = 1'b0;
    redirect   = 1'b0;
    seen_req   = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req)    seen_req   = 1'b1;
      if (inst_valid) seen_valid = 1'b1;
    end
    check_val("t6_halted_req",   {15'd0, seen_req},   16'd0);
    check_val("t6_halted_valid", {15'd0, seen_valid}, 16'd0);
    do_reset();
    @(negedge clk);
    check_val("t6_restart_req",  {15'd0, mem_req}, 16'd1);
    check_val("t6_restart_addr", mem_addr,         16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
